sc_mux_sched: RTL

- Sequences a 2-bit, 2:1 stochastic-computing MUX (scaled adder, Y = S ? B : A) over one bitstream of programmable length.
- Generates the pseudo-random select stream from an 8-bit LFSR compared against a programmable weight, so P(S=1) = weight/255.
- Enables the upstream stream generators while running and counts ones on both MUX output lanes.
- Sits between the CGRA PE configuration/control logic and the SC MUX datapath.

---
 rtl/sc_mux_sched.sv | 105 ++++++++++
 1 files changed

// File: rtl/sc_mux_sched.sv
// SC 2:1 MUX sequencer: LFSR select stream, SNG enable, ones counting.
// Optional per-run seed input: SC_MUX_SCHED_SEED_PORT_EN.
module sc_mux_sched #(
  parameter int          LEN_W = 8,
  parameter logic [7:0]  SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       weight,
`ifdef SC_MUX_SCHED_SEED_PORT_EN
  input  logic [7:0]       seed_in,
`endif
  input  logic [1:0]       y_in,
  output logic             sel,
  output logic             strm_en,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] cnt0,
  output logic [LEN_W-1:0] cnt1
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [7:0] SEED_FIX = (SEED == 8'h00) ? 8'h01 : SEED;

  state_t           state_q;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] cnt0_q;
  logic [LEN_W-1:0] cnt1_q;
  logic [7:0]       w_q;
  logic [7:0]       lfsr_q;
  logic [7:0]       lfsr_d;
  logic [7:0]       seed_ld;
  logic [LEN_W-1:0] inc0;
  logic [LEN_W-1:0] inc1;

`ifdef SC_MUX_SCHED_SEED_PORT_EN
  assign seed_ld = (seed_in == 8'h00) ? 8'h01 : seed_in;
`else
  assign seed_ld = SEED_FIX;
`endif

  // x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0
  assign lfsr_d = {lfsr_q[6:0],
                   lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  assign inc0 = {{(LEN_W-1){1'b0}}, y_in[0]};
  assign inc1 = {{(LEN_W-1){1'b0}}, y_in[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      w_q     <= '0;
      lfsr_q  <= SEED_FIX;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
            if (len != '0) begin
              rem_q   <= len;
              w_q     <= weight;
              lfsr_q  <= seed_ld;
              state_q <= RUN;
            end else begin
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            cnt0_q <= cnt0_q + inc0;
            cnt1_q <= cnt1_q + inc1;
            lfsr_q <= lfsr_d;
            rem_q  <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = (state_q == RUN);
  assign strm_en = busy;
  assign sel     = busy && (lfsr_q <= w_q);
  assign done    = (state_q == DONE);
  assign cnt0    = cnt0_q;
  assign cnt1    = cnt1_q;

endmodule
